fifo_demux8_writer: RTL and testbench
=====================================

Name: fifo_demux8_writer

Overview:
- Write-side counterpart of the scheduler's 8:1 FIFO read multiplexer.
- Accepts 128-bit entries tagged with a 3-bit channel address from the scheduler over a valid/ready handshake, and buffers them in a 2-entry in-order queue.
- Drives wr_en/din into one of eight channel FIFOs, honouring each FIFO's full flag.
- Flags a sticky error when the head entry is blocked by a full FIFO for too long.

Parameters:
- DATA_W, 128, entry width on in_data and din.
- STALL_LIMIT, 1024, consecutive blocked cycles before stall_err sets; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  scheduler presents an entry.
- in_ready  output  1  block can accept an entry this cycle.
- in_addr  input  3  target channel 0..7.
- in_data  input  DATA_W  entry payload.
- wr_en  output  8  one-hot write enable; bit i writes channel FIFO i.
- din  output  DATA_W  shared write data to all eight FIFOs.
- full  input  8  full flag of channel FIFO i.
- stall_err  output  1  sticky head-of-line stall error.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Reset (sync, active-high): buffer cleared, occupancy=0, stall counter=0, stall_err=0.
- While reset is high: in_ready=0, wr_en=8'h00, din=0, regardless of buffer contents.
- Any entries held when reset asserts mid-operation are dropped; no write occurs in the reset cycle.
- Buffer: 2-entry FIFO of {addr, data}, strictly in order. There is no bypass around the head; head-of-line blocking is intended.
- in_ready = !reset && (occupancy != 2). It is combinational from registered occupancy and never depends on in_valid.
- Accept: an entry is accepted on a rising edge where in_valid && in_ready.
- Issue: wr_en[head_addr] = head_valid && !full[head_addr] && !reset. All other wr_en bits are 0; at most one bit is ever set.
- Pop: the head pops on the same edge where wr_en is high.
- din = head_data when head_valid, else 0. din changes only when the head changes.
- Latency: an entry accepted at edge N is first driven on wr_en in cycle N+1; minimum accept-to-write latency is 1 cycle.
- Throughput: 1 entry/cycle sustained when targets are not full.
- Simultaneous push and pop: occupancy is unchanged. At occupancy=2 no push is possible, because in_ready=0 that cycle.
- Order: the pushed entry always lands behind the existing entries.
- full sampling: combinational, same cycle as wr_en, so a FIFO is never written while it reports full.
- full flags of non-head channels are ignored.
- in_addr is a 3-bit field, so every value is legal; there is no default/discard path.
- Stall counter: 16 bits.
  - Increments each cycle that head_valid && full[head_addr].
  - Clears to 0 on any pop, or when the buffer is empty.
  - Saturates at STALL_LIMIT.
- stall_err: set on the edge where the counter becomes STALL_LIMIT; stays 1 until reset. Normal operation continues while it is set.
- Data integrity: payload and address of every accepted entry are written exactly once, to exactly the addressed FIFO, in acceptance order.

Decomposition:
- Shared package fifo_mux_pkg:
  - NUM_CH=8, ADDR_W=3, DATA_W=128.
  - Entry struct/typedef {addr[ADDR_W-1:0], data[DATA_W-1:0]}.
  - The read-side mux uses the same constants.
- One sub-module: entry_buf2, a 2-deep synchronous FIFO with push/pop/occupancy/head outputs.
- The top level holds the channel decode, full gating and stall counter.

Test Plan:
- Reset then idle:
  - reset high 3 cycles with in_valid=1 -> in_ready=0, wr_en=0, occupancy=0, stall_err=0 throughout.
  - In the first cycle after release, in_ready=1.
- Streaming:
  - 16 back-to-back entries, addr=i%8, data=i, full=0 -> in_ready stays 1.
  - wr_en bit (i%8) and din=i each one cycle after acceptance; 16 writes total, in order.
- Backpressure:
  - full[5]=1; push addr=5 data=A, then addr=2 data=B, then a third entry -> occupancy=2, in_ready=0, wr_en=0.
  - On full[5]=0 -> wr_en[5] with din=A, next cycle wr_en[2] with din=B.
- Stall error, with STALL_LIMIT=4:
  - full[3] held at 1 with head addr=3 -> stall_err rises after the 4th blocked cycle.
  - Releasing full[3] -> write occurs, but stall_err remains 1 until reset.
- Simultaneous push/pop:
  - occupancy=1, target not full, in_valid=1 -> occupancy stays 1 over 10 cycles, one write per cycle.
- Reset mid-operation:
  - Assert reset with occupancy=2 and full=0 -> wr_en=0 in the reset cycle.
  - Both entries are never written; occupancy=0 after the edge.

Source files
------------

// File: rtl/fifo_mux_pkg.sv
// Constants and entry type shared by the scheduler's 8:1 FIFO read mux and
// the 1:8 write-side demux.
package fifo_mux_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 128;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_CH-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/entry_buf2.sv
// Two-deep in-order queue of {addr, data}; head is read straight from storage
// so the head payload only changes when the head entry changes.
module entry_buf2
  import fifo_mux_pkg::*;
#(
  parameter int unsigned W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [W-1:0]      push_data,
  input  logic              pop,
  output logic [1:0]        occupancy,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [W-1:0]      head_data
);

  logic [ADDR_W-1:0] r_addr [2];
  logic [W-1:0]      r_data [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = push && (r_count != 2'd2);
  assign w_pop  = pop  && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while r_count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= push_addr;
      r_data[r_wr_ptr] <= push_data;
    end
  end

  assign occupancy  = r_count;
  assign head_valid = (r_count != 2'd0);
  assign head_addr  = r_addr[r_rd_ptr];
  assign head_data  = r_data[r_rd_ptr];

endmodule

// File: rtl/fifo_demux8_writer.sv
// Write side of the scheduler FIFO mux: queues addressed entries and writes
// each into its channel FIFO, tracking head-of-line stalls on full FIFOs.
module fifo_demux8_writer #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [fifo_mux_pkg::ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]                in_data,
  output logic [fifo_mux_pkg::NUM_CH-1:0]  wr_en,
  output logic [DATA_W-1:0]                din,
  input  logic [fifo_mux_pkg::NUM_CH-1:0]  full,
  output logic                             stall_err,
  output logic [1:0]                       occupancy
);

  import fifo_mux_pkg::*;

  localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

  logic              w_push;
  logic              w_pop;
  logic              w_head_valid;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [1:0]        w_occupancy;
  logic              w_blocked;
  logic [15:0]       r_stall_cnt;
  logic              r_stall_err;

  entry_buf2 #(.W(DATA_W)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_addr  (in_addr),
    .push_data  (in_data),
    .pop        (w_pop),
    .occupancy  (w_occupancy),
    .head_valid (w_head_valid),
    .head_addr  (w_head_addr),
    .head_data  (w_head_data)
  );

  assign in_ready  = !reset && (w_occupancy != 2'd2);
  assign w_push    = in_valid && in_ready;
  assign w_blocked = w_head_valid && full[w_head_addr];
  assign w_pop     = w_head_valid && !full[w_head_addr] && !reset;

  assign wr_en     = w_pop ? ch_onehot(w_head_addr) : '0;
  assign din       = (w_head_valid && !reset) ? w_head_data : '0;
  assign occupancy = w_occupancy;
  assign stall_err = r_stall_err;

  // Counter saturates at LIMIT; the sticky error is raised on the edge that
  // takes it there and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else if (w_pop || !w_head_valid) begin
      r_stall_cnt <= '0;
    end else if (w_blocked && (r_stall_cnt != LIMIT)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
      if (r_stall_cnt == LIMIT - 16'd1) r_stall_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_demux8_writer.sv
// Bench for fifo_demux8_writer: scenario tasks plus a scoreboard that matches
// every channel write against the entries accepted, in order.
module tb_fifo_demux8_writer;

  import fifo_mux_pkg::*;

  localparam int unsigned TB_DW    = 128;
  localparam int unsigned TB_LIMIT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_addr;
  logic [127:0] in_data;
  logic [7:0]   wr_en;
  logic [127:0] din;
  logic [7:0]   full;
  logic         stall_err;
  logic [1:0]   occupancy;

  int     n_pass  = 0;
  int     n_total = 0;
  entry_t sb[$];

  always #5 clk = ~clk;

  fifo_demux8_writer #(.DATA_W(TB_DW), .STALL_LIMIT(TB_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .din       (din),
    .full      (full),
    .stall_err (stall_err),
    .occupancy (occupancy)
  );

  // Scoreboard: writes are matched against the oldest accepted entry before
  // this cycle's accept (if any) is queued; reset drops everything held.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (wr_en !== 8'h00) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_write: wr_en=%h din=%h, required no write", wr_en, din);
        end else if (wr_en !== (8'b1 << sb[0].addr) || din !== sb[0].data) begin
          $display("FAIL sb_write: wr_en=%h din=%h, required wr_en=%h din=%h",
                   wr_en, din, 8'b1 << sb[0].addr, sb[0].data);
        end else begin
          n_pass++;
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back('{addr: in_addr, data: in_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_addr = 3'd1; in_data = 128'h77; full = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({in_ready, wr_en, occupancy, stall_err, din} !== {1'b0, 8'h00, 2'd0, 1'b0, 128'd0})
        $display("FAIL reset_outputs: ready=%b wr_en=%h occ=%0d err=%b din=%h, required 0/00/0/0/0",
                 in_ready, wr_en, occupancy, stall_err, din);
      else n_pass++;
      step();
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0)
      $display("FAIL reset_release: ready=%b occ=%0d, required 1/0", in_ready, occupancy);
    else n_pass++;
    step();
  endtask

  task automatic test_streaming();
    int         writes = 0;
    logic [7:0] ew;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        in_valid = 1'b1; in_addr = 3'(i % 8); in_data = 128'(i);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (wr_en !== 8'h00) writes++;
      if (i < 16) begin
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL stream_ready: ready=%b cycle %0d, required 1", in_ready, i);
        else n_pass++;
      end
      if (i > 0) begin
        ew = 8'b1 << ((i - 1) % 8);
        n_total++;
        if (wr_en !== ew || din !== 128'(i - 1))
          $display("FAIL stream_write: wr_en=%h din=%h, required %h/%h", wr_en, din, ew, 128'(i - 1));
        else n_pass++;
      end
      step();
    end
    @(negedge clk);
    n_total++;
    if (writes != 16 || occupancy !== 2'd0)
      $display("FAIL stream_count: writes=%0d occ=%0d, required 16/0", writes, occupancy);
    else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    logic [127:0] da = 128'hAAAA_0000_0000_0000_0000_0000_0000_AAAA;
    logic [127:0] db = 128'hBBBB_1111_2222_3333_4444_5555_6666_BBBB;
    logic [127:0] dc = 128'hCCCC_0000_0000_0000_0000_0000_0000_CCCC;
    full = 8'h20;
    in_valid = 1'b1; in_addr = 3'd5; in_data = da;
    @(negedge clk); step();
    in_addr = 3'd2; in_data = db;
    @(negedge clk);
    n_total++;
    if (wr_en !== 8'h00) $display("FAIL bp_blocked_head: wr_en=%h, required 00", wr_en);
    else n_pass++;
    step();
    in_addr = 3'd6; in_data = dc;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || wr_en !== 8'h00)
        $display("FAIL bp_full_buf: occ=%0d ready=%b wr_en=%h, required 2/0/00", occupancy, in_ready, wr_en);
      else n_pass++;
      step();
    end
    full = 8'h00;
    @(negedge clk);
    n_total++;
    if (wr_en !== 8'h20 || din !== da) $display("FAIL bp_release_a: wr_en=%h din=%h, required 20/%h", wr_en, din, da);
    else n_pass++;
    step();
    @(negedge clk);
    n_total++;
    if (wr_en !== 8'h04 || din !== db) $display("FAIL bp_release_b: wr_en=%h din=%h, required 04/%h", wr_en, din, db);
    else n_pass++;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (wr_en !== 8'h40 || din !== dc) $display("FAIL bp_release_c: wr_en=%h din=%h, required 40/%h", wr_en, din, dc);
    else n_pass++;
    step();
    @(negedge clk);
    n_total++;
    if (occupancy !== 2'd0 || stall_err !== 1'b0)
      $display("FAIL bp_drain: occ=%0d err=%b, required 0/0 (3 blocked cycles < limit)", occupancy, stall_err);
    else n_pass++;
    step();
  endtask

  task automatic test_stall();
    logic [127:0] dd = 128'hD00D_F00D_0123_4567_89AB_CDEF_0000_0003;
    reset = 1'b1; in_valid = 1'b0; full = 8'h00;
    step(); step();
    reset = 1'b0;
    full = 8'h08; in_valid = 1'b1; in_addr = 3'd3; in_data = dd;
    @(negedge clk); step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_total++;
      if (stall_err !== 1'b0 || wr_en !== 8'h00)
        $display("FAIL stall_early: err=%b wr_en=%h blocked cycle %0d, required 0/00", stall_err, wr_en, k);
      else n_pass++;
      step();
    end
    @(negedge clk);
    n_total++;
    if (stall_err !== 1'b1) $display("FAIL stall_set: err=%b, required 1", stall_err);
    else n_pass++;
    step();
    full = 8'h00;
    @(negedge clk);
    n_total++;
    if (wr_en !== 8'h08 || din !== dd || stall_err !== 1'b1)
      $display("FAIL stall_release: wr_en=%h din=%h err=%b, required 08/%h/1", wr_en, din, stall_err, dd);
    else n_pass++;
    step();
    @(negedge clk);
    n_total++;
    if (stall_err !== 1'b1 || occupancy !== 2'd0)
      $display("FAIL stall_sticky: err=%b occ=%0d, required 1/0", stall_err, occupancy);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ea [11];
    logic [127:0] ed [11];
    for (int k = 0; k < 11; k++) begin
      ea[k] = 3'($urandom_range(0, 7));
      ed[k] = {$urandom, $urandom, $urandom, $urandom};
    end
    full = 8'h00;
    for (int k = 0; k < 12; k++) begin
      if (k < 11) begin
        in_valid = 1'b1; in_addr = ea[k]; in_data = ed[k];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (k > 0) begin
        n_total++;
        if ((k < 11 && occupancy !== 2'd1) || wr_en !== (8'b1 << ea[k-1]) || din !== ed[k-1])
          $display("FAIL b2b_cycle: occ=%0d wr_en=%h din=%h, required 1/%h/%h",
                   occupancy, wr_en, din, 8'b1 << ea[k-1], ed[k-1]);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    full = 8'hFF;
    in_valid = 1'b1; in_addr = 3'd1; in_data = 128'h1111;
    @(negedge clk); step();
    in_addr = 3'd4; in_data = 128'h4444;
    @(negedge clk); step();
    in_valid = 1'b0; full = 8'h00; reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (wr_en !== 8'h00 || din !== 128'd0 || in_ready !== 1'b0 || occupancy !== 2'd2)
      $display("FAIL rstmid_cycle: wr_en=%h din=%h ready=%b occ=%0d, required 00/0/0/2",
               wr_en, din, in_ready, occupancy);
    else n_pass++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (occupancy !== 2'd0 || wr_en !== 8'h00 || stall_err !== 1'b0)
        $display("FAIL rstmid_after: occ=%0d wr_en=%h err=%b, required 0/00/0", occupancy, wr_en, stall_err);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; full = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: %0d entries never written, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
